// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a 2**FifoDepthLog2-byte FIFO; define UART_RX_PARITY_EN for 8E1 with parityError.
// Byte is visible two cycles after stop-bit centre; when full and not popped, a new byte is dropped with an overrun pulse.
module uart_rx_fifo #(
    parameter int ClkFrequency  = 100_000_000,
    parameter int Baud          = 115200,
    parameter int Oversample    = 16,
    parameter int FifoDepthLog2 = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   uartRx,
    output logic [7:0]             dataOut,
    output logic                   dataValid,
    input  logic                   dataReady,
    output logic [FifoDepthLog2:0] fifoCount,
    output logic                   overrun,
    output logic                   frameError
`ifdef UART_RX_PARITY_EN
    ,
    output logic                   parityError
`endif
);
    localparam int Div   = ClkFrequency / (Baud * Oversample);
    localparam int DivW  = (Div > 1) ? $clog2(Div) : 1;
    localparam int OsW   = $clog2(Oversample);
    localparam int Depth = 1 << FifoDepthLog2;

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_HIGH
`ifdef UART_RX_PARITY_EN
        , S_PARITY
`endif
    } state_t;

    logic [1:0]      r_sync;
    logic            w_rx_s;
    logic [DivW-1:0] r_div_cnt;
    logic            w_tick;

    state_t          r_state, w_state_nxt;
    logic [OsW-1:0]  r_os_cnt, w_os_nxt;
    logic [2:0]      r_bit_idx, w_bit_nxt;
    logic [7:0]      r_shift, w_shift_nxt;
    logic            r_push, w_push_nxt;
    logic            r_frame_err, w_fe_nxt;
    logic            w_mid, w_full_bit;
`ifdef UART_RX_PARITY_EN
    logic            r_par, w_par_nxt;
    logic            r_par_err, w_pe_nxt;
`endif

    logic [7:0]               r_mem [Depth];
    logic [FifoDepthLog2-1:0] r_wr_ptr, r_rd_ptr;
    logic [FifoDepthLog2:0]   r_count;
    logic                     r_overrun;
    logic                     w_pop, w_full, w_wr, w_ovr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_sync <= 2'b11;
        else     r_sync <= {r_sync[0], uartRx};
    end
    assign w_rx_s = r_sync[1];

    assign w_tick = (r_div_cnt == DivW'(Div - 1));
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         r_div_cnt <= '0;
        else if (w_tick) r_div_cnt <= '0;
        else             r_div_cnt <= r_div_cnt + 1'b1;
    end

    assign w_mid      = w_tick && (r_os_cnt == OsW'(Oversample / 2 - 1));
    assign w_full_bit = w_tick && (r_os_cnt == OsW'(Oversample - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_os_cnt    <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_push      <= 1'b0;
            r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par       <= 1'b0;
            r_par_err   <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_os_cnt    <= w_os_nxt;
            r_bit_idx   <= w_bit_nxt;
            r_shift     <= w_shift_nxt;
            r_push      <= w_push_nxt;
            r_frame_err <= w_fe_nxt;
`ifdef UART_RX_PARITY_EN
            r_par       <= w_par_nxt;
            r_par_err   <= w_pe_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_os_nxt    = r_os_cnt;
        w_bit_nxt   = r_bit_idx;
        w_shift_nxt = r_shift;
        w_push_nxt  = 1'b0;
        w_fe_nxt    = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_nxt   = r_par;
        w_pe_nxt    = 1'b0;
`endif
        if (w_tick) w_os_nxt = r_os_cnt + 1'b1;
        case (r_state)
            S_IDLE: begin
                w_os_nxt = '0;
                if (!w_rx_s) w_state_nxt = S_START;
            end
            S_START: if (w_mid) begin
                w_os_nxt  = '0;
                w_bit_nxt = '0;
                w_state_nxt = w_rx_s ? S_IDLE : S_DATA;
            end
            S_DATA: if (w_full_bit) begin
                w_os_nxt    = '0;
                w_shift_nxt = {w_rx_s, r_shift[7:1]};
                w_bit_nxt   = r_bit_idx + 3'd1;
`ifdef UART_RX_PARITY_EN
                if (r_bit_idx == 3'd7) w_state_nxt = S_PARITY;
`else
                if (r_bit_idx == 3'd7) w_state_nxt = S_STOP;
`endif
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: if (w_full_bit) begin
                w_os_nxt    = '0;
                w_par_nxt   = w_rx_s;
                w_state_nxt = S_STOP;
            end
`endif
            S_STOP: if (w_full_bit) begin
                w_os_nxt = '0;
                if (!w_rx_s) begin
                    // A broken stop bit outranks a parity failure.
                    w_fe_nxt    = 1'b1;
                    w_state_nxt = S_WAIT_HIGH;
                end else begin
`ifdef UART_RX_PARITY_EN
                    if (^{r_shift, r_par}) w_pe_nxt   = 1'b1;
                    else                   w_push_nxt = 1'b1;
`else
                    w_push_nxt = 1'b1;
`endif
                    w_state_nxt = S_IDLE;
                end
            end
            S_WAIT_HIGH: if (w_rx_s) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_pop  = dataReady && (r_count != '0);
    assign w_full = (r_count == (FifoDepthLog2 + 1)'(Depth));
    assign w_wr   = r_push && (!w_full || w_pop);
    assign w_ovr  = r_push && w_full && !w_pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < Depth; i++) r_mem[i] <= 8'h00;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_wr) begin
                r_mem[r_wr_ptr] <= r_shift;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_wr && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_wr && w_pop) r_count <= r_count - 1'b1;
            r_overrun <= w_ovr;
        end
    end

    assign dataOut    = r_mem[r_rd_ptr];
    assign dataValid  = (r_count != '0);
    assign fifoCount  = r_count;
    assign overrun    = r_overrun;
    assign frameError = r_frame_err;
`ifdef UART_RX_PARITY_EN
    assign parityError = r_par_err;
`endif
endmodule
